gpio_repeater_filtered: RTL

Parametrised successor to the two-bit GPIO pass-through used between the Renode DPI bridge outputs and inputs. It takes Width asynchronous GPIO lines from Renode and synchronises, debounces and transforms each line under a per-channel mode. It drives the result back to Renode inputs, together with single-cycle edge event strobes. It sits in the sim top between renode_outputs and renode_inputs, clocked by the same clk.

---
 rtl/gpio_repeater_filtered.sv | 129 ++++++++++++
 1 files changed

// File: rtl/gpio_repeater_filtered.sv
// gpio_repeater_filtered
// Per-channel GPIO conditioning between the Renode DPI bridge outputs and
// inputs: synchronise, debounce, then drive out under a per-channel mode
// (pass / invert / toggle / stretch), with one-cycle rise/fall strobes.
//
// Pipeline per channel:
//   in -> sync_chain (SyncStages) -> filt (debounced, accepted value)
//      -> filt_d (previous accepted value) -> rise/fall/out registers.
// The output stage treats filt as the "next" accepted value and filt_d as the
// current one. This keeps out, rise and fall coincident, one posedge after
// filt is updated.
module gpio_repeater_filtered #(
  parameter int Width         = 2,
  parameter int SyncStages    = 2,
  parameter int FilterCycles  = 4,
  parameter int StretchCycles = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*Width-1:0]   mode,
  input  logic [Width-1:0]     in,
  output logic [Width-1:0]     out,
  output logic [Width-1:0]     rise,
  output logic [Width-1:0]     fall
);

  localparam int CntW = $clog2(FilterCycles) + 1;
  localparam int StrW = $clog2(StretchCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(FilterCycles - 1);
  localparam logic [StrW-1:0] StrLoad = StrW'(StretchCycles);

  localparam logic [1:0] ModePass    = 2'b00;
  localparam logic [1:0] ModeInvert  = 2'b01;
  localparam logic [1:0] ModeToggle  = 2'b10;
  localparam logic [1:0] ModeStretch = 2'b11;

  logic [SyncStages-1:0][Width-1:0] sync_chain;
  logic [Width-1:0]                 sync;
  logic [Width-1:0]                 filt;
  logic [Width-1:0]                 filt_d;
  logic [Width-1:0][CntW-1:0]       cnt;
  logic [Width-1:0]                 toggle_q;
  logic [Width-1:0][StrW-1:0]       stretch_q;

  logic [Width-1:0]                 rise_next;
  logic [Width-1:0]                 fall_next;
  logic [Width-1:0]                 toggle_next;
  logic [Width-1:0][StrW-1:0]       stretch_next;
  logic [Width-1:0]                 out_next;

  assign sync = sync_chain[SyncStages-1];

  // Multi-flop synchroniser: shift the raw inputs through SyncStages flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[SyncStages-2:0], in};
    end
  end

  // Debounce: accept the synchronised value only after it has differed from
  // the accepted value for FilterCycles consecutive cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt <= '0;
      cnt  <= '0;
    end else begin
      for (int i = 0; i < Width; i++) begin
        if (sync[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CntLast) begin
          filt[i] <= sync[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Next-state for the output stage: edges, toggle, stretch and mode mux.
  always_comb begin
    rise_next    = '0;
    fall_next    = '0;
    toggle_next  = toggle_q;
    stretch_next = stretch_q;
    out_next     = '0;
    for (int i = 0; i < Width; i++) begin
      rise_next[i]   = filt[i] & ~filt_d[i];
      fall_next[i]   = ~filt[i] & filt_d[i];
      toggle_next[i] = toggle_q[i] ^ rise_next[i];
      if (rise_next[i]) begin
        stretch_next[i] = StrLoad;
      end else if (stretch_q[i] != '0) begin
        stretch_next[i] = stretch_q[i] - 1'b1;
      end else begin
        stretch_next[i] = '0;
      end
      case (mode[2*i +: 2])
        ModePass:    out_next[i] = filt[i];
        ModeInvert:  out_next[i] = ~filt[i];
        ModeToggle:  out_next[i] = toggle_next[i];
        ModeStretch: out_next[i] = (stretch_next[i] != '0);
        default:     out_next[i] = filt[i];
      endcase
    end
  end

  // Output stage registers; reset forces out low even in invert mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_d    <= '0;
      toggle_q  <= '0;
      stretch_q <= '0;
      rise      <= '0;
      fall      <= '0;
      out       <= '0;
    end else begin
      filt_d    <= filt;
      toggle_q  <= toggle_next;
      stretch_q <= stretch_next;
      rise      <= rise_next;
      fall      <= fall_next;
      out       <= out_next;
    end
  end

endmodule
